cpl_write_engine: RTL and testbench
===================================

# cpl_write_engine

Completion write engine that sits downstream of the completion queue manager and drives its enqueue request, enqueue response and enqueue commit channels. For each completion record offered by a producer, it reserves a slot in the target completion queue, writes the record to host memory through a DMA write descriptor, waits for the DMA status, then commits the slot. It processes one completion at a time and returns a per-request status (success, queue full, error) to the producer.

## Interface
Parameters:
- QUEUE_INDEX_WIDTH, 8, completion queue index width
- REQ_TAG_WIDTH, 8, producer request tag width
- OP_TAG_WIDTH, 6, queue manager op tag width; equals clog2 of the queue manager OP_TABLE_SIZE
- ADDR_WIDTH, 64, host address width
- CPL_SIZE, 16, completion record size in bytes; power of two, minimum 4
- DMA_TAG_WIDTH, 8, DMA descriptor tag width
- DMA_LEN_WIDTH, 16, DMA length field width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_axis_req_queue / _tag / _data / _valid / _ready  in,in,in,in,out  QUEUE_INDEX_WIDTH / REQ_TAG_WIDTH / CPL_SIZE*8 / 1 / 1  producer completion request
- m_axis_req_status_tag / _full / _error / _valid  out  REQ_TAG_WIDTH / 1 / 1 / 1  per-request status, single-cycle pulse, no ready
- m_axis_enqueue_req_queue / _tag / _valid / _ready  out,out,out,in  QUEUE_INDEX_WIDTH / REQ_TAG_WIDTH / 1 / 1  slot reservation to queue manager
- s_axis_enqueue_resp_addr / _phase / _tag / _op_tag / _full / _error / _valid / _ready  in×7,out  ADDR_WIDTH / 1 / REQ_TAG_WIDTH / OP_TAG_WIDTH / 1 / 1 / 1 / 1  reservation response
- m_axis_dma_write_desc_dma_addr / _len / _tag / _data / _valid / _ready  out×5,in  ADDR_WIDTH / DMA_LEN_WIDTH / DMA_TAG_WIDTH / CPL_SIZE*8 / 1 / 1  DMA write descriptor with inline data
- s_axis_dma_write_desc_status_tag / _error / _valid  in  DMA_TAG_WIDTH / 1 / 1  DMA completion status
- m_axis_enqueue_commit_op_tag / _valid / _ready  out,out,in  OP_TAG_WIDTH / 1 / 1  slot commit

## Operation
- FSM states: IDLE, ENQ_REQ, ENQ_RESP, DMA_DESC, DMA_WAIT, COMMIT, STATUS.
- IDLE: s_axis_req_ready=1; on handshake latch queue, tag, data -> ENQ_REQ.
- ENQ_REQ: enqueue_req_valid=1 with latched queue/tag; on ready -> ENQ_RESP.
- ENQ_RESP: enqueue_resp_ready=1; on valid latch all fields. If full or error: status full/error flags set -> STATUS (no DMA, no commit). Otherwise -> DMA_DESC.
- DMA_DESC: descriptor valid; dma_addr=resp addr, len=CPL_SIZE, tag=internal DMA tag counter, data=latched record; on ready -> DMA_WAIT.
- DMA_WAIT: accept a status only when status tag equals the issued tag; mismatched or out-of-state statuses are discarded. On match: record the DMA error bit -> COMMIT.
- COMMIT: commit_valid=1 with latched op_tag; on ready -> STATUS. Commit is issued even after a DMA error, so the op table never leaks.
- STATUS: status_valid=1 for exactly one cycle, tag=request tag, full=resp full, error=resp error OR DMA error -> IDLE.
- DMA tag counter increments by 1 per issued descriptor, wraps modulo 2^DMA_TAG_WIDTH.
- Response tag mismatch with latched request tag: treated as error (error=1, no DMA, no commit).

## Timing
- Reset: FSM to IDLE; DMA tag counter to 0; every valid output and enqueue_resp_ready 0; s_axis_req_ready 0 during the reset cycle and 1 the cycle after; data/addr outputs 0.
- All outputs registered. Valid outputs are held with stable payload until ready.
- With zero-wait peers: request handshake at cycle 0, enqueue_req at cycle 1, response accepted at cycle 2, descriptor at cycle 3, status accepted at cycle 4 at the earliest, commit at cycle 5, status pulse at cycle 6, ready again at cycle 7. Minimum spacing is one completion per 7 cycles.
- Full/error path: status pulse 1 cycle after the response handshake.
- Reset mid-operation abandons the current op without issuing a commit. A DMA status that arrives later is ignored.

## Configuration
- CPL_WRITE_PHASE_EN defined: bit 7 of the last record byte (data bit CPL_SIZE*8-1) is replaced with resp phase before the descriptor is issued.
- Undefined: the record is written unchanged, and s_axis_enqueue_resp_phase is ignored.

## Structure
- Package cpl_write_pkg holds the FSM state enum, the status-flag struct (full, error), and the CPL_PHASE_BIT localparam function of CPL_SIZE.
- One sub-module is natural: cpl_req_reg, a single-entry holding register for the request payload.

## Test plan
- Request queue 3, tag 0x15, zero-wait peers: descriptor len 16, tag 0, commit of resp op_tag 5; status pulse tag 0x15, full=0, error=0, 6 cycles after accept.
- Response with full=1: no descriptor, no commit; status full=1 one cycle after the response.
- DMA status with tag 7, then tag 0 with error=1, while expecting 0: tag 7 is ignored; commit is still issued; status error=1.
- 256 back-to-back requests: DMA tags run 0..255 then wrap to 0; every request gets exactly one commit and one status.
- Hold commit_ready low for 10 cycles: commit_valid and op_tag stay stable; status pulses exactly once after the handshake.
- Assert rst in DMA_WAIT: all valids are 0 on the next cycle; a stale DMA status is ignored; the next request completes normally with DMA tag 0.

Source files
------------

// File: rtl/cpl_write_pkg.sv
// Shared types for the completion write engine: FSM states, status flags and
// the location of the phase bit inside a completion record.
package cpl_write_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENQ_REQ,
    ENQ_RESP,
    DMA_DESC,
    DMA_WAIT,
    COMMIT,
    STATUS
  } cpl_state_e;

  typedef struct packed {
    logic full;
    logic error;
  } cpl_status_t;

  // Phase lives in bit 7 of the last byte of the record.
  function automatic int cplPhaseBit(input int cplSize);
    return cplSize * 8 - 1;
  endfunction

endpackage

// File: rtl/cpl_req_reg.sv
// Single-entry holding register for the producer request payload; the phase
// bit of the record can be overwritten once the reservation response arrives.
module cpl_req_reg #(
  parameter int QUEUE_INDEX_WIDTH = 8,
  parameter int REQ_TAG_WIDTH     = 8,
  parameter int DATA_WIDTH        = 128,
  parameter int PHASE_BIT         = 127
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_i,
  input  logic [QUEUE_INDEX_WIDTH-1:0] queue_i,
  input  logic [REQ_TAG_WIDTH-1:0]     tag_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         phaseWr_i,
  input  logic                         phase_i,
  output logic [QUEUE_INDEX_WIDTH-1:0] queue_o,
  output logic [REQ_TAG_WIDTH-1:0]     tag_o,
  output logic [DATA_WIDTH-1:0]        data_o
);

  logic [QUEUE_INDEX_WIDTH-1:0] queue_q;
  logic [REQ_TAG_WIDTH-1:0]     tag_q;
  logic [DATA_WIDTH-1:0]        data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      queue_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      queue_q <= queue_i;
      tag_q   <= tag_i;
      data_q  <= data_i;
    end else if (phaseWr_i) begin
      data_q[PHASE_BIT] <= phase_i;
    end
  end

  assign queue_o = queue_q;
  assign tag_o   = tag_q;
  assign data_o  = data_q;

endmodule

// File: rtl/cpl_write_engine.sv
// Completion write engine: reserve a CQ slot, DMA the record, commit, report.
// Optional CPL_WRITE_PHASE_EN stamps the response phase into the record.
module cpl_write_engine
  import cpl_write_pkg::*;
#(
  parameter int QUEUE_INDEX_WIDTH = 8,
  parameter int REQ_TAG_WIDTH     = 8,
  parameter int OP_TAG_WIDTH      = 6,
  parameter int ADDR_WIDTH        = 64,
  parameter int CPL_SIZE          = 16,
  parameter int DMA_TAG_WIDTH     = 8,
  parameter int DMA_LEN_WIDTH     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_req_queue,
  input  logic [REQ_TAG_WIDTH-1:0]     s_axis_req_tag,
  input  logic [CPL_SIZE*8-1:0]        s_axis_req_data,
  input  logic                         s_axis_req_valid,
  output logic                         s_axis_req_ready,
  output logic [REQ_TAG_WIDTH-1:0]     m_axis_req_status_tag,
  output logic                         m_axis_req_status_full,
  output logic                         m_axis_req_status_error,
  output logic                         m_axis_req_status_valid,
  output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_enqueue_req_queue,
  output logic [REQ_TAG_WIDTH-1:0]     m_axis_enqueue_req_tag,
  output logic                         m_axis_enqueue_req_valid,
  input  logic                         m_axis_enqueue_req_ready,
  input  logic [ADDR_WIDTH-1:0]        s_axis_enqueue_resp_addr,
  input  logic                         s_axis_enqueue_resp_phase,
  input  logic [REQ_TAG_WIDTH-1:0]     s_axis_enqueue_resp_tag,
  input  logic [OP_TAG_WIDTH-1:0]      s_axis_enqueue_resp_op_tag,
  input  logic                         s_axis_enqueue_resp_full,
  input  logic                         s_axis_enqueue_resp_error,
  input  logic                         s_axis_enqueue_resp_valid,
  output logic                         s_axis_enqueue_resp_ready,
  output logic [ADDR_WIDTH-1:0]        m_axis_dma_write_desc_dma_addr,
  output logic [DMA_LEN_WIDTH-1:0]     m_axis_dma_write_desc_len,
  output logic [DMA_TAG_WIDTH-1:0]     m_axis_dma_write_desc_tag,
  output logic [CPL_SIZE*8-1:0]        m_axis_dma_write_desc_data,
  output logic                         m_axis_dma_write_desc_valid,
  input  logic                         m_axis_dma_write_desc_ready,
  input  logic [DMA_TAG_WIDTH-1:0]     s_axis_dma_write_desc_status_tag,
  input  logic                         s_axis_dma_write_desc_status_error,
  input  logic                         s_axis_dma_write_desc_status_valid,
  output logic [OP_TAG_WIDTH-1:0]      m_axis_enqueue_commit_op_tag,
  output logic                         m_axis_enqueue_commit_valid,
  input  logic                         m_axis_enqueue_commit_ready
);

  localparam int DATA_WIDTH    = CPL_SIZE * 8;
  localparam int CPL_PHASE_BIT = cplPhaseBit(CPL_SIZE);

  cpl_state_e                   state_q, state_d;
  cpl_status_t                  flags_q, flags_d;
  logic [DMA_TAG_WIDTH-1:0]     dmaTag_q;
  logic [ADDR_WIDTH-1:0]        dmaAddr_q;
  logic [OP_TAG_WIDTH-1:0]      opTag_q;
  logic                         reqReady_q, enqReqValid_q, respReady_q;
  logic                         descValid_q, commitValid_q, statusValid_q;
  logic [QUEUE_INDEX_WIDTH-1:0] reqQueue;
  logic [REQ_TAG_WIDTH-1:0]     reqTag;
  logic [DATA_WIDTH-1:0]        reqData;
  logic                         reqFire, enqReqFire, respFire, descFire;
  logic                         dmaMatch, commitFire, phaseWr;

  assign reqFire    = s_axis_req_valid && reqReady_q;
  assign enqReqFire = enqReqValid_q && m_axis_enqueue_req_ready;
  assign respFire   = respReady_q && s_axis_enqueue_resp_valid;
  assign descFire   = descValid_q && m_axis_dma_write_desc_ready;
  assign commitFire = commitValid_q && m_axis_enqueue_commit_ready;
  // Statuses carrying any other tag belong to some abandoned op and are dropped.
  assign dmaMatch   = (state_q == DMA_WAIT) && s_axis_dma_write_desc_status_valid &&
                      (s_axis_dma_write_desc_status_tag == dmaTag_q);

`ifdef CPL_WRITE_PHASE_EN
  assign phaseWr = respFire;
`else
  assign phaseWr = 1'b0;
`endif

  cpl_req_reg #(
    .QUEUE_INDEX_WIDTH(QUEUE_INDEX_WIDTH),
    .REQ_TAG_WIDTH    (REQ_TAG_WIDTH),
    .DATA_WIDTH       (DATA_WIDTH),
    .PHASE_BIT        (CPL_PHASE_BIT)
  ) reqReg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (reqFire),
    .queue_i  (s_axis_req_queue),
    .tag_i    (s_axis_req_tag),
    .data_i   (s_axis_req_data),
    .phaseWr_i(phaseWr),
    .phase_i  (s_axis_enqueue_resp_phase),
    .queue_o  (reqQueue),
    .tag_o    (reqTag),
    .data_o   (reqData)
  );

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    unique case (state_q)
      IDLE: begin
        if (reqFire) begin
          flags_d = '0;
          state_d = ENQ_REQ;
        end
      end
      ENQ_REQ: if (enqReqFire) state_d = ENQ_RESP;
      ENQ_RESP: begin
        if (respFire) begin
          flags_d.full  = s_axis_enqueue_resp_full;
          flags_d.error = s_axis_enqueue_resp_error ||
                          (s_axis_enqueue_resp_tag != reqTag);
          state_d = (flags_d.full || flags_d.error) ? STATUS : DMA_DESC;
        end
      end
      DMA_DESC: if (descFire) state_d = DMA_WAIT;
      DMA_WAIT: begin
        if (dmaMatch) begin
          flags_d.error = flags_q.error || s_axis_dma_write_desc_status_error;
          state_d = COMMIT;
        end
      end
      COMMIT: if (commitFire) state_d = STATUS;
      STATUS: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so each is a clean flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      flags_q       <= '0;
      dmaTag_q      <= '0;
      dmaAddr_q     <= '0;
      opTag_q       <= '0;
      reqReady_q    <= 1'b0;
      enqReqValid_q <= 1'b0;
      respReady_q   <= 1'b0;
      descValid_q   <= 1'b0;
      commitValid_q <= 1'b0;
      statusValid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flags_q       <= flags_d;
      reqReady_q    <= (state_d == IDLE);
      enqReqValid_q <= (state_d == ENQ_REQ);
      respReady_q   <= (state_d == ENQ_RESP);
      descValid_q   <= (state_d == DMA_DESC);
      commitValid_q <= (state_d == COMMIT);
      statusValid_q <= (state_d == STATUS);
      if (respFire) begin
        dmaAddr_q <= s_axis_enqueue_resp_addr;
        opTag_q   <= s_axis_enqueue_resp_op_tag;
      end
      if (dmaMatch) dmaTag_q <= dmaTag_q + DMA_TAG_WIDTH'(1);
    end
  end

  assign s_axis_req_ready               = reqReady_q;
  assign m_axis_req_status_tag          = reqTag;
  assign m_axis_req_status_full         = flags_q.full;
  assign m_axis_req_status_error        = flags_q.error;
  assign m_axis_req_status_valid        = statusValid_q;
  assign m_axis_enqueue_req_queue       = reqQueue;
  assign m_axis_enqueue_req_tag         = reqTag;
  assign m_axis_enqueue_req_valid       = enqReqValid_q;
  assign s_axis_enqueue_resp_ready      = respReady_q;
  assign m_axis_dma_write_desc_dma_addr = dmaAddr_q;
  assign m_axis_dma_write_desc_len      = DMA_LEN_WIDTH'(CPL_SIZE);
  assign m_axis_dma_write_desc_tag      = dmaTag_q;
  assign m_axis_dma_write_desc_data     = reqData;
  assign m_axis_dma_write_desc_valid    = descValid_q;
  assign m_axis_enqueue_commit_op_tag   = opTag_q;
  assign m_axis_enqueue_commit_valid    = commitValid_q;

endmodule

// File: tb/tb_cpl_write_engine.sv
// Self-checking bench for cpl_write_engine: bench-side peers plus a
// transaction-level model of expected status, DMA tags and commits.
module tb_cpl_write_engine;

  localparam bit PHASE_EN =
`ifdef CPL_WRITE_PHASE_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0]   s_axis_req_queue = '0, s_axis_req_tag = '0;
  logic [127:0] s_axis_req_data = '0;
  logic         s_axis_req_valid = 1'b0, s_axis_req_ready;
  logic [7:0]   m_axis_req_status_tag;
  logic         m_axis_req_status_full, m_axis_req_status_error, m_axis_req_status_valid;
  logic [7:0]   m_axis_enqueue_req_queue, m_axis_enqueue_req_tag;
  logic         m_axis_enqueue_req_valid, m_axis_enqueue_req_ready = 1'b0;
  logic [63:0]  s_axis_enqueue_resp_addr = '0;
  logic         s_axis_enqueue_resp_phase = 1'b0;
  logic [7:0]   s_axis_enqueue_resp_tag = '0;
  logic [5:0]   s_axis_enqueue_resp_op_tag = '0;
  logic         s_axis_enqueue_resp_full = 1'b0, s_axis_enqueue_resp_error = 1'b0;
  logic         s_axis_enqueue_resp_valid = 1'b0, s_axis_enqueue_resp_ready;
  logic [63:0]  m_axis_dma_write_desc_dma_addr;
  logic [15:0]  m_axis_dma_write_desc_len;
  logic [7:0]   m_axis_dma_write_desc_tag;
  logic [127:0] m_axis_dma_write_desc_data;
  logic         m_axis_dma_write_desc_valid, m_axis_dma_write_desc_ready = 1'b0;
  logic [7:0]   s_axis_dma_write_desc_status_tag = '0;
  logic         s_axis_dma_write_desc_status_error = 1'b0, s_axis_dma_write_desc_status_valid = 1'b0;
  logic [5:0]   m_axis_enqueue_commit_op_tag;
  logic         m_axis_enqueue_commit_valid, m_axis_enqueue_commit_ready = 1'b0;

  int checks = 0;
  int passes = 0;
  int modelTag = 0;

  int enqCycle, respCycle, descCycle, commitCycle, statusCycle, readyCycle;
  int descCount, commitCount, statusCount;
  logic [7:0]   obsEnqQueue, obsEnqTag, obsStatusTag, obsDescTag;
  logic         obsFull, obsErr;
  logic [63:0]  obsDescAddr;
  logic [15:0]  obsDescLen;
  logic [127:0] obsDescData;
  logic [5:0]   obsCommitOp;
  bit           commitStable, timedOut;

  cpl_write_engine dut (
    .clk(clk), .rst(rst),
    .s_axis_req_queue(s_axis_req_queue), .s_axis_req_tag(s_axis_req_tag),
    .s_axis_req_data(s_axis_req_data), .s_axis_req_valid(s_axis_req_valid),
    .s_axis_req_ready(s_axis_req_ready),
    .m_axis_req_status_tag(m_axis_req_status_tag), .m_axis_req_status_full(m_axis_req_status_full),
    .m_axis_req_status_error(m_axis_req_status_error), .m_axis_req_status_valid(m_axis_req_status_valid),
    .m_axis_enqueue_req_queue(m_axis_enqueue_req_queue), .m_axis_enqueue_req_tag(m_axis_enqueue_req_tag),
    .m_axis_enqueue_req_valid(m_axis_enqueue_req_valid), .m_axis_enqueue_req_ready(m_axis_enqueue_req_ready),
    .s_axis_enqueue_resp_addr(s_axis_enqueue_resp_addr), .s_axis_enqueue_resp_phase(s_axis_enqueue_resp_phase),
    .s_axis_enqueue_resp_tag(s_axis_enqueue_resp_tag), .s_axis_enqueue_resp_op_tag(s_axis_enqueue_resp_op_tag),
    .s_axis_enqueue_resp_full(s_axis_enqueue_resp_full), .s_axis_enqueue_resp_error(s_axis_enqueue_resp_error),
    .s_axis_enqueue_resp_valid(s_axis_enqueue_resp_valid), .s_axis_enqueue_resp_ready(s_axis_enqueue_resp_ready),
    .m_axis_dma_write_desc_dma_addr(m_axis_dma_write_desc_dma_addr), .m_axis_dma_write_desc_len(m_axis_dma_write_desc_len),
    .m_axis_dma_write_desc_tag(m_axis_dma_write_desc_tag), .m_axis_dma_write_desc_data(m_axis_dma_write_desc_data),
    .m_axis_dma_write_desc_valid(m_axis_dma_write_desc_valid), .m_axis_dma_write_desc_ready(m_axis_dma_write_desc_ready),
    .s_axis_dma_write_desc_status_tag(s_axis_dma_write_desc_status_tag),
    .s_axis_dma_write_desc_status_error(s_axis_dma_write_desc_status_error),
    .s_axis_dma_write_desc_status_valid(s_axis_dma_write_desc_status_valid),
    .m_axis_enqueue_commit_op_tag(m_axis_enqueue_commit_op_tag), .m_axis_enqueue_commit_valid(m_axis_enqueue_commit_valid),
    .m_axis_enqueue_commit_ready(m_axis_enqueue_commit_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] expData(input logic [127:0] d, input logic ph);
    logic [127:0] r;
    r = d;
    if (PHASE_EN) r[127] = ph;
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic clearPeers();
    m_axis_enqueue_req_ready = 1'b0;
    s_axis_enqueue_resp_valid = 1'b0;
    m_axis_dma_write_desc_ready = 1'b0;
    s_axis_dma_write_desc_status_valid = 1'b0;
    m_axis_enqueue_commit_ready = 1'b0;
  endtask

  // Plays producer and all downstream peers for one completion; records what
  // the DUT did, cycle numbers counted from the request handshake (cycle 0).
  task automatic runOp(input logic [7:0] q, input logic [7:0] t, input logic [127:0] d,
                       input logic [63:0] rAddr, input logic [5:0] rOp, input bit rFull,
                       input bit rErr, input bit rTagBad, input bit rPhase, input bit dErr,
                       input int strayTag, input int commitHold, input bit abortAfterDesc);
    int c, sinceDesc, holdLeft;
    bit rdy, enqDone, respDone, descDone, dmaDone;
    enqCycle = -1; respCycle = -1; descCycle = -1; commitCycle = -1;
    statusCycle = -1; readyCycle = -1;
    descCount = 0; commitCount = 0; statusCount = 0;
    commitStable = 1'b1; timedOut = 1'b0;
    s_axis_req_queue = q; s_axis_req_tag = t; s_axis_req_data = d; s_axis_req_valid = 1'b1;
    rdy = 1'b0; c = 0;
    while (!rdy && c < 50) begin
      rdy = s_axis_req_ready;
      @(posedge clk); #1;
      c++;
    end
    s_axis_req_valid = 1'b0;
    if (!rdy) begin
      timedOut = 1'b1;
      return;
    end
    holdLeft = commitHold; sinceDesc = 0;
    enqDone = 0; respDone = 0; descDone = 0; dmaDone = 0;
    for (c = 1; c <= 80 && readyCycle < 0; c++) begin
      if (abortAfterDesc && descDone) break;
      clearPeers();
      if (m_axis_req_status_valid) begin
        statusCount++;
        if (statusCycle < 0) begin
          statusCycle = c; obsStatusTag = m_axis_req_status_tag;
          obsFull = m_axis_req_status_full; obsErr = m_axis_req_status_error;
        end
      end
      if (m_axis_enqueue_commit_valid) begin
        if (commitCycle < 0) begin
          commitCycle = c; obsCommitOp = m_axis_enqueue_commit_op_tag;
        end else if (m_axis_enqueue_commit_op_tag !== obsCommitOp) commitStable = 1'b0;
        if (holdLeft > 0) holdLeft--;
        else begin
          m_axis_enqueue_commit_ready = 1'b1;
          commitCount++;
        end
      end
      if (descDone && !dmaDone && !abortAfterDesc) begin
        s_axis_dma_write_desc_status_valid = 1'b1;
        if (strayTag >= 0 && sinceDesc == 0) begin
          s_axis_dma_write_desc_status_tag = 8'(strayTag);
          s_axis_dma_write_desc_status_error = !dErr;
        end else begin
          s_axis_dma_write_desc_status_tag = obsDescTag;
          s_axis_dma_write_desc_status_error = dErr;
          dmaDone = 1'b1;
        end
        sinceDesc++;
      end
      if (m_axis_dma_write_desc_valid) begin
        if (descCycle < 0) begin
          descCycle = c; obsDescAddr = m_axis_dma_write_desc_dma_addr;
          obsDescLen = m_axis_dma_write_desc_len; obsDescTag = m_axis_dma_write_desc_tag;
          obsDescData = m_axis_dma_write_desc_data;
        end
        m_axis_dma_write_desc_ready = 1'b1;
        descCount++;
        descDone = 1'b1;
      end
      if (enqDone && !respDone) begin
        s_axis_enqueue_resp_valid = 1'b1;
        s_axis_enqueue_resp_addr = rAddr; s_axis_enqueue_resp_op_tag = rOp;
        s_axis_enqueue_resp_tag = rTagBad ? (t ^ 8'h01) : t;
        s_axis_enqueue_resp_full = rFull; s_axis_enqueue_resp_error = rErr;
        s_axis_enqueue_resp_phase = rPhase;
        if (s_axis_enqueue_resp_ready) begin
          respDone = 1'b1; respCycle = c;
        end
      end
      if (m_axis_enqueue_req_valid) begin
        if (enqCycle < 0) begin
          enqCycle = c; obsEnqQueue = m_axis_enqueue_req_queue; obsEnqTag = m_axis_enqueue_req_tag;
        end
        m_axis_enqueue_req_ready = 1'b1;
        enqDone = 1'b1;
      end
      if (s_axis_req_ready && statusCount > 0) readyCycle = c;
      if (readyCycle < 0) begin
        @(posedge clk); #1;
      end
    end
    clearPeers();
    if (!abortAfterDesc && readyCycle < 0) timedOut = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (s_axis_req_ready !== 1'b0) $display("[TB] FAIL reset_req_ready got %0b want 0", s_axis_req_ready); else passes++;
    checks++; if (m_axis_enqueue_req_valid !== 1'b0) $display("[TB] FAIL reset_enq_valid got %0b want 0", m_axis_enqueue_req_valid); else passes++;
    checks++; if (s_axis_enqueue_resp_ready !== 1'b0) $display("[TB] FAIL reset_resp_ready got %0b want 0", s_axis_enqueue_resp_ready); else passes++;
    checks++; if (m_axis_dma_write_desc_valid !== 1'b0) $display("[TB] FAIL reset_desc_valid got %0b want 0", m_axis_dma_write_desc_valid); else passes++;
    checks++; if (m_axis_enqueue_commit_valid !== 1'b0) $display("[TB] FAIL reset_commit_valid got %0b want 0", m_axis_enqueue_commit_valid); else passes++;
    checks++; if (m_axis_req_status_valid !== 1'b0) $display("[TB] FAIL reset_status_valid got %0b want 0", m_axis_req_status_valid); else passes++;
    checks++; if (m_axis_dma_write_desc_data !== 128'd0) $display("[TB] FAIL reset_desc_data got %0h want 0", m_axis_dma_write_desc_data); else passes++;
    checks++; if (m_axis_dma_write_desc_dma_addr !== 64'd0) $display("[TB] FAIL reset_desc_addr got %0h want 0", m_axis_dma_write_desc_dma_addr); else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (s_axis_req_ready !== 1'b1) $display("[TB] FAIL post_reset_ready got %0b want 1", s_axis_req_ready); else passes++;
    modelTag = 0;
  endtask

  task automatic test_basic();
    logic [127:0] d;
    logic [63:0] a;
    bit ph;
    d = rand128(); a = {$urandom(), $urandom()}; ph = 1'($urandom_range(0, 1));
    runOp(8'h03, 8'h15, d, a, 6'd5, 0, 0, 0, ph, 0, -1, 0, 0);
    checks++; if (timedOut) $display("[TB] FAIL basic_timeout got timeout want completion"); else passes++;
    checks++; if (obsEnqQueue !== 8'h03 || obsEnqTag !== 8'h15) $display("[TB] FAIL basic_enq got q=%0h t=%0h want q=3 t=15", obsEnqQueue, obsEnqTag); else passes++;
    checks++; if (obsDescLen !== 16'd16) $display("[TB] FAIL basic_len got %0d want 16", obsDescLen); else passes++;
    checks++; if (obsDescTag !== 8'(modelTag)) $display("[TB] FAIL basic_dma_tag got %0d want %0d", obsDescTag, modelTag); else passes++;
    checks++; if (obsDescAddr !== a) $display("[TB] FAIL basic_addr got %0h want %0h", obsDescAddr, a); else passes++;
    checks++; if (obsDescData !== expData(d, ph)) $display("[TB] FAIL basic_data got %0h want %0h", obsDescData, expData(d, ph)); else passes++;
    checks++; if (obsCommitOp !== 6'd5 || commitCount !== 1) $display("[TB] FAIL basic_commit got op=%0d n=%0d want op=5 n=1", obsCommitOp, commitCount); else passes++;
    checks++; if (statusCount !== 1 || obsStatusTag !== 8'h15 || obsFull !== 1'b0 || obsErr !== 1'b0)
      $display("[TB] FAIL basic_status got n=%0d tag=%0h full=%0b err=%0b want n=1 tag=15 full=0 err=0", statusCount, obsStatusTag, obsFull, obsErr); else passes++;
    checks++; if (enqCycle !== 1 || descCycle !== 3 || commitCycle !== 5 || statusCycle !== 6 || readyCycle !== 7)
      $display("[TB] FAIL basic_latency got enq=%0d desc=%0d commit=%0d status=%0d ready=%0d want 1/3/5/6/7",
               enqCycle, descCycle, commitCycle, statusCycle, readyCycle); else passes++;
    modelTag = (modelTag + 1) % 256;
  endtask

  // Full, error and tag-mismatch responses skip DMA and commit entirely.
  task automatic test_resp_reject();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] t;
      t = 8'($urandom());
      runOp(8'($urandom()), t, rand128(), {$urandom(), $urandom()}, 6'($urandom()),
            k == 0, k == 1, k == 2, 0, 0, -1, 0, 0);
      checks++; if (timedOut) $display("[TB] FAIL reject%0d_timeout got timeout want completion", k); else passes++;
      checks++; if (descCount !== 0 || commitCount !== 0) $display("[TB] FAIL reject%0d_no_dma got desc=%0d commit=%0d want 0/0", k, descCount, commitCount); else passes++;
      checks++; if (statusCount !== 1 || obsStatusTag !== t || obsFull !== (k == 0) || obsErr !== (k != 0))
        $display("[TB] FAIL reject%0d_status got n=%0d tag=%0h full=%0b err=%0b want n=1 tag=%0h full=%0b err=%0b",
                 k, statusCount, obsStatusTag, obsFull, obsErr, t, k == 0, k != 0); else passes++;
      checks++; if (statusCycle !== respCycle + 1) $display("[TB] FAIL reject%0d_latency got %0d want %0d", k, statusCycle, respCycle + 1); else passes++;
    end
  endtask

  task automatic test_stray_dma();
    int stray;
    stray = (modelTag + 7) % 256;
    runOp(8'h01, 8'h22, rand128(), {$urandom(), $urandom()}, 6'd9, 0, 0, 0, 0, 1, stray, 0, 0);
    checks++; if (timedOut) $display("[TB] FAIL stray_timeout got timeout want completion"); else passes++;
    checks++; if (obsDescTag !== 8'(modelTag)) $display("[TB] FAIL stray_dma_tag got %0d want %0d", obsDescTag, modelTag); else passes++;
    checks++; if (commitCount !== 1 || commitCycle !== 6 || obsCommitOp !== 6'd9)
      $display("[TB] FAIL stray_commit got n=%0d cyc=%0d op=%0d want n=1 cyc=6 op=9", commitCount, commitCycle, obsCommitOp); else passes++;
    checks++; if (statusCount !== 1 || obsErr !== 1'b1 || obsFull !== 1'b0)
      $display("[TB] FAIL stray_status got n=%0d err=%0b full=%0b want n=1 err=1 full=0", statusCount, obsErr, obsFull); else passes++;
    modelTag = (modelTag + 1) % 256;
  endtask

  task automatic test_commit_hold();
    runOp(8'h07, 8'h31, rand128(), {$urandom(), $urandom()}, 6'd42, 0, 0, 0, 0, 0, -1, 10, 0);
    checks++; if (timedOut) $display("[TB] FAIL hold_timeout got timeout want completion"); else passes++;
    checks++; if (!commitStable || obsCommitOp !== 6'd42) $display("[TB] FAIL hold_stable got stable=%0b op=%0d want stable=1 op=42", commitStable, obsCommitOp); else passes++;
    checks++; if (commitCount !== 1) $display("[TB] FAIL hold_commit_count got %0d want 1", commitCount); else passes++;
    checks++; if (statusCount !== 1 || statusCycle !== commitCycle + 11)
      $display("[TB] FAIL hold_status got n=%0d cyc=%0d want n=1 cyc=%0d", statusCount, statusCycle, commitCycle + 11); else passes++;
    modelTag = (modelTag + 1) % 256;
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    for (int i = 0; i < 260; i++) begin
      logic [7:0] t;
      logic [127:0] d;
      logic [63:0] a;
      logic [5:0] op;
      bit de, ph;
      t = 8'($urandom()); d = rand128(); a = {$urandom(), $urandom()}; op = 6'($urandom());
      de = 1'($urandom_range(0, 1)); ph = 1'($urandom_range(0, 1));
      runOp(8'($urandom()), t, d, a, op, 0, 0, 0, ph, de, -1, 0, 0);
      checks++; if (timedOut || readyCycle !== 7) begin $display("[TB] FAIL b2b%0d_spacing got ready=%0d to=%0b want 7", i, readyCycle, timedOut); bad++; end else passes++;
      checks++; if (obsDescTag !== 8'(modelTag)) begin $display("[TB] FAIL b2b%0d_dma_tag got %0d want %0d", i, obsDescTag, modelTag); bad++; end else passes++;
      checks++; if (obsDescData !== expData(d, ph) || obsDescAddr !== a) begin $display("[TB] FAIL b2b%0d_desc got %0h@%0h want %0h@%0h", i, obsDescData, obsDescAddr, expData(d, ph), a); bad++; end else passes++;
      checks++; if (commitCount !== 1 || obsCommitOp !== op) begin $display("[TB] FAIL b2b%0d_commit got n=%0d op=%0d want n=1 op=%0d", i, commitCount, obsCommitOp, op); bad++; end else passes++;
      checks++; if (statusCount !== 1 || obsStatusTag !== t || obsErr !== de || obsFull !== 1'b0)
        begin $display("[TB] FAIL b2b%0d_status got n=%0d tag=%0h err=%0b want n=1 tag=%0h err=%0b", i, statusCount, obsStatusTag, obsErr, t, de); bad++; end else passes++;
      modelTag = (modelTag + 1) % 256;
      if (bad > 10) break;
    end
  endtask

  task automatic test_random_mix();
    for (int i = 0; i < 60; i++) begin
      logic [7:0] t;
      logic [5:0] op;
      bit f, e, tb, de, doDma, expErr;
      int st;
      t = 8'($urandom()); op = 6'($urandom());
      f = ($urandom_range(0, 3) == 0); e = ($urandom_range(0, 3) == 0); tb = ($urandom_range(0, 3) == 0);
      de = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 1) == 1) ? (modelTag + 1 + int'($urandom_range(0, 254))) % 256 : -1;
      doDma = !(f || e || tb);
      expErr = e || tb || (doDma && de);
      runOp(8'($urandom()), t, rand128(), {$urandom(), $urandom()}, op, f, e, tb,
            1'($urandom_range(0, 1)), de, st, int'($urandom_range(0, 3)), 0);
      checks++; if (timedOut) $display("[TB] FAIL mix%0d_timeout got timeout want completion", i); else passes++;
      checks++; if (descCount !== int'(doDma) || commitCount !== int'(doDma))
        $display("[TB] FAIL mix%0d_counts got desc=%0d commit=%0d want %0d", i, descCount, commitCount, doDma); else passes++;
      checks++; if (statusCount !== 1 || obsStatusTag !== t || obsFull !== f || obsErr !== expErr)
        $display("[TB] FAIL mix%0d_status got n=%0d tag=%0h full=%0b err=%0b want n=1 tag=%0h full=%0b err=%0b",
                 i, statusCount, obsStatusTag, obsFull, obsErr, t, f, expErr); else passes++;
      if (doDma) begin
        checks++; if (obsDescTag !== 8'(modelTag) || obsCommitOp !== op)
          $display("[TB] FAIL mix%0d_dma got tag=%0d op=%0d want tag=%0d op=%0d", i, obsDescTag, obsCommitOp, modelTag, op); else passes++;
        modelTag = (modelTag + 1) % 256;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] oldTag;
    int st;
    runOp(8'h02, 8'h44, rand128(), {$urandom(), $urandom()}, 6'd3, 0, 0, 0, 0, 0, -1, 0, 1);
    checks++; if (descCount !== 1) $display("[TB] FAIL midrst_reached_wait got desc=%0d want 1", descCount); else passes++;
    oldTag = obsDescTag;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({m_axis_enqueue_req_valid, s_axis_enqueue_resp_ready, m_axis_dma_write_desc_valid,
                   m_axis_enqueue_commit_valid, m_axis_req_status_valid, s_axis_req_ready} !== 6'b0)
      $display("[TB] FAIL midrst_outputs got %06b want 000000", {m_axis_enqueue_req_valid, s_axis_enqueue_resp_ready,
               m_axis_dma_write_desc_valid, m_axis_enqueue_commit_valid, m_axis_req_status_valid, s_axis_req_ready}); else passes++;
    rst = 1'b0;
    s_axis_dma_write_desc_status_valid = 1'b1;
    s_axis_dma_write_desc_status_tag = oldTag;
    s_axis_dma_write_desc_status_error = 1'b1;
    @(posedge clk); #1;
    s_axis_dma_write_desc_status_valid = 1'b0;
    checks++; if (s_axis_req_ready !== 1'b1 || m_axis_enqueue_commit_valid !== 1'b0)
      $display("[TB] FAIL midrst_idle got ready=%0b commit=%0b want 1/0", s_axis_req_ready, m_axis_enqueue_commit_valid); else passes++;
    modelTag = 0;
    st = (oldTag != 8'd0) ? int'(oldTag) : -1;
    runOp(8'h09, 8'h55, rand128(), {$urandom(), $urandom()}, 6'd17, 0, 0, 0, 0, 0, st, 0, 0);
    checks++; if (timedOut) $display("[TB] FAIL midrst_next_timeout got timeout want completion"); else passes++;
    checks++; if (obsDescTag !== 8'd0) $display("[TB] FAIL midrst_next_tag got %0d want 0", obsDescTag); else passes++;
    checks++; if (commitCount !== 1 || obsCommitOp !== 6'd17 || commitCycle !== ((st >= 0) ? 6 : 5))
      $display("[TB] FAIL midrst_next_commit got n=%0d op=%0d cyc=%0d want n=1 op=17 cyc=%0d",
               commitCount, obsCommitOp, commitCycle, (st >= 0) ? 6 : 5); else passes++;
    checks++; if (statusCount !== 1 || obsErr !== 1'b0 || obsStatusTag !== 8'h55)
      $display("[TB] FAIL midrst_next_status got n=%0d err=%0b tag=%0h want n=1 err=0 tag=55", statusCount, obsErr, obsStatusTag); else passes++;
    modelTag = (modelTag + 1) % 256;
  endtask

  initial begin
    $display("[TB] cpl_write_engine bench start (phase stamping %0s)", PHASE_EN ? "on" : "off");
    #1;
    test_reset();
    test_basic();
    test_resp_reject();
    test_stray_dma();
    test_commit_hold();
    test_back_to_back();
    test_random_mix();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
